// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: control-flag bit positions, default widths
// and the packed control bundle carried from decode into execute.
package pipe_pkg;

  localparam int unsigned PC_W   = 48;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam int unsigned MEM_RD_BIT = 2;
  localparam int unsigned MEM_WR_BIT = 1;
  localparam int unsigned WB_WR_BIT  = 1;

  typedef struct packed {
    logic [3:0] flagsALU;
    logic [2:0] flagsMEM;
    logic [1:0] flagsWB;
  } idex_ctrl_t;

  // Clearing every control flag guarantees no memory or register-bank write.
  localparam idex_ctrl_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load sitting in EX whose destination is
// read by the instruction currently in decode.
module load_use_detect #(
  parameter int unsigned REG_W = pipe_pkg::REG_W
) (
  input  logic             ex_valid,
  input  logic             ex_mem_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             hazard
);

  always_comb begin
    hazard = ex_valid && ex_mem_rd && id_valid && (ex_rd != '0)
             && ((ex_rd == rs) || (ex_rd == rt));
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W   = pipe_pkg::PC_W,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_W  = pipe_pkg::REG_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   pc1,
  input  logic [3:0]        flagsALU,
  input  logic [2:0]        flagsMEM,
  input  logic [1:0]        flagsWB,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] dataOne,
  input  logic [DATA_W-1:0] dataTwo,
  input  logic [DATA_W-1:0] immediate,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc1,
  output logic [3:0]        ex_flagsALU,
  output logic [2:0]        ex_flagsMEM,
  output logic [1:0]        ex_flagsWB,
  output logic [5:0]        ex_opcode,
  output logic [DATA_W-1:0] ex_dataOne,
  output logic [DATA_W-1:0] ex_dataTwo,
  output logic [DATA_W-1:0] ex_immediate,
  output logic [REG_W-1:0]  ex_rd,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  idex_ctrl_t ex_ctrl;
  idex_ctrl_t id_ctrl;
  logic       hazard;
  logic       bubble;

  assign id_ctrl     = '{flagsALU: flagsALU, flagsMEM: flagsMEM, flagsWB: flagsWB};
  assign ex_flagsALU = ex_ctrl.flagsALU;
  assign ex_flagsMEM = ex_ctrl.flagsMEM;
  assign ex_flagsWB  = ex_ctrl.flagsWB;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valid  (ex_valid),
    .ex_mem_rd (ex_ctrl.flagsMEM[MEM_RD_BIT]),
    .id_valid  (id_valid),
    .ex_rd     (ex_rd),
    .rs        (rs),
    .rt        (rt),
    .hazard    (hazard)
  );

  assign stall_if_id = (hazard && !flush) || hold;
  // Flush outranks hold, hold outranks the hazard bubble.
  assign bubble      = flush || (!hold && hazard);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= IDEX_BUBBLE;
      ex_pc1       <= '0;
      ex_opcode    <= '0;
      ex_dataOne   <= '0;
      ex_dataTwo   <= '0;
      ex_immediate <= '0;
      ex_rd        <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      bubble_cnt   <= '0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= IDEX_BUBBLE;
      ex_pc1       <= '0;
      ex_opcode    <= '0;
      ex_dataOne   <= '0;
      ex_dataTwo   <= '0;
      ex_immediate <= '0;
      ex_rd        <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      if (!flush && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (!hold) begin
      ex_valid     <= id_valid;
      ex_ctrl      <= id_ctrl;
      ex_pc1       <= pc1;
      ex_opcode    <= opcode;
      ex_dataOne   <= dataOne;
      ex_dataTwo   <= dataTwo;
      ex_immediate <= immediate;
      ex_rd        <= rd;
      ex_rs        <= rs;
      ex_rt        <= rt;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a reference model pushes the expected EX
// contents per cycle; they are popped and compared one cycle later.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, id_valid, flush, hold;
  logic [47:0] pc1;
  logic [3:0]  flagsALU;
  logic [2:0]  flagsMEM;
  logic [1:0]  flagsWB;
  logic [5:0]  opcode;
  logic [31:0] dataOne, dataTwo, immediate;
  logic [4:0]  rd, rs, rt;

  logic        ex_valid, stall_if_id;
  logic [47:0] ex_pc1;
  logic [3:0]  ex_flagsALU;
  logic [2:0]  ex_flagsMEM;
  logic [1:0]  ex_flagsWB;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_dataOne, ex_dataTwo, ex_immediate;
  logic [4:0]  ex_rd, ex_rs, ex_rt;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_stall;
  logic [47:0] s_pc1;
  logic [3:0]  s_alu;
  logic [2:0]  s_mem;
  logic [1:0]  s_wb;
  logic [5:0]  s_op;
  logic [31:0] s_d1, s_d2, s_imm;
  logic [4:0]  s_rd, s_rs, s_rt;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .pc1(pc1), .flagsALU(flagsALU),
    .flagsMEM(flagsMEM), .flagsWB(flagsWB), .opcode(opcode), .dataOne(dataOne),
    .dataTwo(dataTwo), .immediate(immediate), .rd(rd), .rs(rs), .rt(rt),
    .flush(flush), .hold(hold), .ex_valid(ex_valid), .ex_pc1(ex_pc1),
    .ex_flagsALU(ex_flagsALU), .ex_flagsMEM(ex_flagsMEM), .ex_flagsWB(ex_flagsWB),
    .ex_opcode(ex_opcode), .ex_dataOne(ex_dataOne), .ex_dataTwo(ex_dataTwo),
    .ex_immediate(ex_immediate), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .pc1(pc1), .flagsALU(flagsALU),
    .flagsMEM(flagsMEM), .flagsWB(flagsWB), .opcode(opcode), .dataOne(dataOne),
    .dataTwo(dataTwo), .immediate(immediate), .rd(rd), .rs(rs), .rt(rt),
    .flush(flush), .hold(hold), .ex_valid(s_valid), .ex_pc1(s_pc1),
    .ex_flagsALU(s_alu), .ex_flagsMEM(s_mem), .ex_flagsWB(s_wb),
    .ex_opcode(s_op), .ex_dataOne(s_d1), .ex_dataTwo(s_d2),
    .ex_immediate(s_imm), .ex_rd(s_rd), .ex_rs(s_rs), .ex_rt(s_rt),
    .stall_if_id(s_stall), .bubble_cnt(s_cnt)
  );

  typedef struct {
    logic        valid;
    logic [47:0] pc1;
    logic [3:0]  alu;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [5:0]  op;
    logic [31:0] d1, d2, imm;
    logic [4:0]  rd, rs, rt;
    int unsigned cnt;
  } exp_t;

  exp_t        m;
  exp_t        sb[$];
  logic        m_known = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [47:0] p, input logic [2:0] me,
                       input logic [1:0] w, input logic [5:0] o, input logic [31:0] x1,
                       input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    id_valid = v; pc1 = p; flagsALU = o[3:0]; flagsMEM = me; flagsWB = w; opcode = o;
    dataOne = x1; dataTwo = ~x1; immediate = {x1[15:0], x1[31:16]};
    rd = d; rs = s; rt = t;
  endtask

  task automatic cycle();
    exp_t e;
    logic hz;
    #1;
    hz = m_known && m.valid && m.mem[2] && id_valid && (m.rd != 0) && (m.rd == rs || m.rd == rt);
    if (m_known) chk("stall", stall_if_id, (hz && !flush) || hold);
    e = m;
    if (!rst || flush || (!hold && hz)) begin
      e.valid = 0; e.pc1 = 0; e.alu = 0; e.mem = 0; e.wb = 0; e.op = 0;
      e.d1 = 0; e.d2 = 0; e.imm = 0; e.rd = 0; e.rs = 0; e.rt = 0;
      if (!rst) e.cnt = 0;
      else if (!flush) e.cnt = m.cnt + 1;
    end else if (!hold) begin
      e.valid = id_valid; e.pc1 = pc1; e.alu = flagsALU; e.mem = flagsMEM; e.wb = flagsWB;
      e.op = opcode; e.d1 = dataOne; e.d2 = dataTwo; e.imm = immediate;
      e.rd = rd; e.rs = rs; e.rt = rt;
    end
    if (!rst) m_known = 1'b1;
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid", ex_valid, e.valid);
    chk("ctrl", {ex_flagsALU, ex_flagsMEM, ex_flagsWB}, {e.alu, e.mem, e.wb});
    chk("pc_op", {ex_pc1, ex_opcode}, {e.pc1, e.op});
    chk("data", {ex_dataOne, ex_dataTwo, ex_immediate}, {e.d1, e.d2, e.imm});
    chk("regs", {ex_rd, ex_rs, ex_rt}, {e.rd, e.rs, e.rt});
    chk("cnt", bubble_cnt, (e.cnt > 65535) ? 65535 : e.cnt);
    chk("cnt4", s_cnt, (e.cnt > 15) ? 15 : e.cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset with random inputs
    repeat (2) begin
      instr(1'($urandom), {16'h0, 32'($urandom)}, 3'($urandom), 2'($urandom), 6'($urandom),
            32'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      flush = 1'($urandom);
      cycle();
    end
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_cnt", bubble_cnt, 16'd0);
    chk("rst_stall", stall_if_id, 1'b0);
    rst = 1'b1; flush = 1'b0;

    // Pass-through
    instr(1, 48'h1, 3'b000, 2'b10, 6'h08, 32'hA5A5_0001, 5, 1, 2);
    cycle();
    chk("pt_pc1", ex_pc1, 48'h1);
    chk("pt_data", ex_dataOne, 32'hA5A5_0001);
    chk("pt_valid", ex_valid, 1'b1);

    // Load-use: one bubble, then the dependent instruction is captured
    instr(1, 48'h2, 3'b100, 2'b10, 6'h23, 32'h1111, 7, 1, 2);
    cycle();
    instr(1, 48'h3, 3'b000, 2'b10, 6'h00, 32'h2222, 8, 7, 3);
    cycle();
    chk("lu_cnt", bubble_cnt, 16'd1);
    chk("lu_mem", ex_flagsMEM, 3'b000);
    cycle();
    chk("lu_rs", ex_rs, 5'd7);
    chk("lu_valid", ex_valid, 1'b1);

    // rd==0 load never stalls
    instr(1, 48'h4, 3'b100, 2'b10, 6'h23, 32'h3333, 0, 1, 2);
    cycle();
    instr(1, 48'h5, 3'b000, 2'b10, 6'h00, 32'h4444, 8, 0, 0);
    cycle();
    chk("rd0_cnt", bubble_cnt, 16'd1);
    chk("rd0_valid", ex_valid, 1'b1);

    // Hazard + flush: bubble without count
    instr(1, 48'h6, 3'b100, 2'b10, 6'h23, 32'h5555, 9, 1, 2);
    cycle();
    instr(1, 48'h7, 3'b000, 2'b10, 6'h00, 32'h6666, 10, 9, 3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fl_cnt", bubble_cnt, 16'd1);

    // Hazard + hold for 3 cycles, then one bubble on release
    instr(1, 48'h8, 3'b100, 2'b10, 6'h23, 32'h7777, 9, 1, 2);
    cycle();
    instr(1, 48'h9, 3'b000, 2'b10, 6'h00, 32'h8888, 10, 3, 9);
    hold = 1'b1;
    repeat (3) begin
      cycle();
      chk("hold_rd", ex_rd, 5'd9);
    end
    hold = 1'b0;
    cycle();
    chk("hold_cnt", bubble_cnt, 16'd2);
    cycle();
    chk("hold_rt", ex_rt, 5'd9);

    // Reset in mid-stall, then a normal capture
    instr(1, 48'hA, 3'b100, 2'b10, 6'h23, 32'h9999, 3, 1, 2);
    cycle();
    instr(1, 48'hB, 3'b000, 2'b10, 6'h00, 32'hAAAA, 4, 3, 5);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rs_valid", ex_valid, 1'b1);
    chk("rs_cnt", bubble_cnt, 16'd0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      instr(1, 48'(i), 3'b100, 2'b10, 6'h23, 32'(i), 5'((i % 31) + 1), 0, 0);
      cycle();
      instr(1, 48'(i + 100), 3'b000, 2'b10, 6'h00, 32'(i), 0, 0, 5'((i % 31) + 1));
      cycle();
      cycle();
    end
    chk("sat4", s_cnt, 4'hF);
    chk("sat16", bubble_cnt, 16'd20);

    // Random traffic over a small register range
    for (int i = 0; i < 300; i++) begin
      instr(1'($urandom_range(0, 3) != 0), {16'h0, 32'($urandom)},
            {1'($urandom), 2'($urandom)}, 2'($urandom), 6'($urandom), 32'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
